// File: rtl/pio_key_debounce_if.sv
// Memory-mapped slave bus of the key debouncer: register access plus level interrupt.
interface pio_key_debounce_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_key_debounce.sv
// Debounced key input port: per-key synchroniser and stability counter, edge capture
// with rise/fall enables, write-1-to-clear capture register and masked level interrupt.
module pio_key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_key_debounce_if.slave bus,
  input  logic [WIDTH-1:0] in_port
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]   INFO_WORD = {DEBOUNCE_CYCLES[23:0], WIDTH[7:0]};

  logic [WIDTH-1:0] r_sync1, r_sync2;
  logic [WIDTH-1:0] r_stable, r_stable_d;
  logic [WIDTH-1:0] r_rise_en, r_fall_en, r_irq_mask, r_edge_cap;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_flip, w_rise, w_fall, w_set, w_clr;
  logic             w_wr;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // A key flips only on the last of DEBOUNCE_CYCLES consecutive mismatching cycles.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CW-1:0] r_cnt;
    logic          w_mismatch;

    assign w_mismatch = r_sync2[gi] ^ r_stable[gi];
    assign w_flip[gi] = w_mismatch && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                     r_cnt <= '0;
      else if (!w_mismatch || w_flip[gi]) r_cnt <= '0;
      else                              r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable   <= '0;
      r_stable_d <= '0;
    end else begin
      r_stable   <= r_stable ^ w_flip;
      r_stable_d <= r_stable;
    end
  end

  assign w_rise = r_stable & ~r_stable_d;
  assign w_fall = ~r_stable & r_stable_d;
  assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_wr   = bus.chipselect && !bus.write_n;
  assign w_clr  = (w_wr && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // Only the low WIDTH bits of a write carry register contents.
  assign w_unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_mask <= '0;
    end else if (w_wr) begin
      if (bus.address == 3'd1) r_rise_en  <= bus.writedata[WIDTH-1:0];
      if (bus.address == 3'd2) r_irq_mask <= bus.writedata[WIDTH-1:0];
      if (bus.address == 3'd4) r_fall_en  <= bus.writedata[WIDTH-1:0];
    end
  end

  // A capture landing in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_edge_cap <= '0;
    else          r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      3'd0:    w_rd_mux = 32'(r_stable);
      3'd1:    w_rd_mux = 32'(r_rise_en);
      3'd2:    w_rd_mux = 32'(r_irq_mask);
      3'd3:    w_rd_mux = 32'(r_edge_cap);
      3'd4:    w_rd_mux = 32'(r_fall_en);
      3'd5:    w_rd_mux = INFO_WORD;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_mux;
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_pio_key_debounce.sv
// Self-checking bench: directed vector table, reset-mid-debounce sequence, and random
// traffic compared against a sliding-window behavioural model of the debouncer.
module tb_pio_key_debounce;
  localparam int W  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] keys = '0;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  pio_key_debounce_if bus();

  pio_key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(keys)
  );

  // Model: a key flips when the last DC synchronised samples all differ from it.
  logic [W-1:0] raw_q[$];
  logic [W-1:0] m_stable, m_stable_d, m_rise_en, m_fall_en, m_mask, m_cap;
  logic [31:0]  m_rd;

  task automatic m_reset();
    raw_q.delete();
    repeat (DC + 2) raw_q.push_back('0);
    m_stable = '0; m_stable_d = '0; m_rise_en = '0; m_fall_en = '0;
    m_mask = '0; m_cap = '0; m_rd = '0;
  endtask

  task automatic m_edge(input logic [2:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [W-1:0] k);
    logic [W-1:0] nstable, rise, fall, clr, ncap, smp;
    logic [31:0]  rd;
    bit           all_diff;
    raw_q.push_back(k);
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int j = 3; j <= DC + 2; j++) begin
        smp = raw_q[raw_q.size() - j];
        if (smp[i] == m_stable[i]) all_diff = 1'b0;
      end
      nstable[i] = all_diff ? ~m_stable[i] : m_stable[i];
    end
    while (raw_q.size() > DC + 2) void'(raw_q.pop_front());
    rise = m_stable & ~m_stable_d;
    fall = ~m_stable & m_stable_d;
    clr  = (cs && !wn && a == 3'd3) ? wd[W-1:0] : '0;
    ncap = (m_cap & ~clr) | (rise & m_rise_en) | (fall & m_fall_en);
    case (a)
      3'd0: rd = 32'(m_stable);
      3'd1: rd = 32'(m_rise_en);
      3'd2: rd = 32'(m_mask);
      3'd3: rd = 32'(m_cap);
      3'd4: rd = 32'(m_fall_en);
      3'd5: rd = (32'(DC) << 8) | 32'(W);
      default: rd = 32'd0;
    endcase
    if (cs && !wn) begin
      if (a == 3'd1) m_rise_en = wd[W-1:0];
      if (a == 3'd2) m_mask    = wd[W-1:0];
      if (a == 3'd4) m_fall_en = wd[W-1:0];
    end
    m_stable_d = m_stable;
    m_stable   = nstable;
    m_cap      = ncap;
    m_rd       = rd;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic [W-1:0] k);
    bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd; keys = k;
    @(posedge clk);
    m_edge(a, cs, wn, wd, k);
    #1;
  endtask

  typedef struct {
    logic [2:0]   addr;
    logic         cs;
    logic         wr_n;
    logic [31:0]  wdata;
    logic [W-1:0] keys;
    int           n;
    logic [31:0]  exp_rd;
    logic         exp_irq;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd,
                     input logic [W-1:0] k, input int n, input logic [31:0] er, input logic ei);
    vec_t v;
    v.addr = a; v.cs = cs; v.wr_n = wn; v.wdata = wd; v.keys = k; v.n = n;
    v.exp_rd = er; v.exp_irq = ei;
    tbl.push_back(v);
  endtask

  task automatic rd(input logic [2:0] a, input logic [W-1:0] k, input int n,
                    input logic [31:0] er, input logic ei);
    add(a, 1'b0, 1'b1, 32'd0, k, n, er, ei);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [W-1:0] k,
                    input logic [31:0] er, input logic ei);
    add(a, 1'b1, 1'b0, wd, k, 1, er, ei);
  endtask

  initial begin
    logic [W-1:0] rk;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

    // Key change seen at row-edge 1 lands in stable at edge 6 and readdata at edge 7.
    rd(0, 4'h0, 1, 32'h0, 0);
    rd(0, 4'h1, 6, 32'h0, 0);
    rd(0, 4'h1, 1, 32'h1, 0);
    rd(0, 4'h3, 3, 32'h1, 0);
    rd(0, 4'h1, 8, 32'h1, 0);
    rd(3, 4'h1, 1, 32'h0, 0);
    wr(1, 32'h1, 4'h1, 32'h0, 0);
    wr(2, 32'h1, 4'h1, 32'h0, 0);
    rd(0, 4'h0, 9, 32'h0, 0);
    rd(3, 4'h1, 6, 32'h0, 0);
    rd(3, 4'h1, 1, 32'h0, 1);
    rd(3, 4'h1, 1, 32'h1, 1);
    wr(3, 32'h1, 4'h1, 32'h1, 0);
    rd(3, 4'h1, 1, 32'h0, 0);
    wr(4, 32'h4, 4'h1, 32'h0, 0);
    wr(1, 32'h0, 4'h1, 32'h1, 0);
    rd(3, 4'h5, 9, 32'h0, 0);
    rd(3, 4'h1, 7, 32'h0, 0);
    rd(3, 4'h1, 1, 32'h4, 0);
    wr(3, 32'h4, 4'h1, 32'h4, 0);
    rd(3, 4'h1, 1, 32'h0, 0);
    wr(1, 32'h8, 4'h1, 32'h0, 0);
    rd(0, 4'h9, 6, 32'h1, 0);
    wr(3, 32'h8, 4'h9, 32'h0, 0);
    rd(3, 4'h9, 1, 32'h8, 0);
    wr(2, 32'h9, 4'h9, 32'h1, 1);
    rd(2, 4'h9, 1, 32'h9, 1);
    rd(5, 4'h9, 1, 32'h00000404, 1);
    rd(6, 4'h9, 1, 32'h0, 1);
    rd(7, 4'h9, 1, 32'h0, 1);
    add(2, 1'b0, 1'b0, 32'h0, 4'h9, 1, 32'h9, 1);
    add(2, 1'b1, 1'b1, 32'h0, 4'h9, 1, 32'h9, 1);
    wr(6, 32'hFFFFFFFF, 4'h9, 32'h0, 1);
    rd(4, 4'h9, 1, 32'h4, 1);
    rd(1, 4'h9, 1, 32'h8, 1);
    rd(0, 4'h9, 1, 32'h9, 1);
    wr(1, 32'hFFFFFFF8, 4'h9, 32'h8, 1);
    rd(1, 4'h9, 1, 32'h8, 1);
    wr(3, 32'hFFFFFFFF, 4'h9, 32'h8, 0);
    rd(3, 4'h9, 1, 32'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset readdata", bus.readdata, 32'h0);
    check("reset irq", 32'(bus.irq), 32'h0);
    reset_n = 1'b1;
    m_reset();

    foreach (tbl[vi]) begin
      for (int c = 0; c < tbl[vi].n; c++)
        step(tbl[vi].addr, tbl[vi].cs, tbl[vi].wr_n, tbl[vi].wdata, tbl[vi].keys);
      $display("vec %0d addr=%0d cs=%0b wr_n=%0b wdata=%08h keys=%h x%0d -> rd=%08h irq=%0b",
               vi, tbl[vi].addr, tbl[vi].cs, tbl[vi].wr_n, tbl[vi].wdata, tbl[vi].keys,
               tbl[vi].n, bus.readdata, bus.irq);
      check($sformatf("vec%0d readdata", vi), bus.readdata, tbl[vi].exp_rd);
      check($sformatf("vec%0d irq", vi), 32'(bus.irq), 32'(tbl[vi].exp_irq));
    end

    // Reset in the middle of a pending key1 change: everything clears at once.
    for (int c = 0; c < 3; c++) step(3'd0, 1'b0, 1'b1, 32'd0, 4'hB);
    #3 reset_n = 1'b0;
    #1;
    check("async reset readdata", bus.readdata, 32'h0);
    check("async reset irq", 32'(bus.irq), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
    for (int c = 0; c < 6; c++) step(3'd0, 1'b0, 1'b1, 32'd0, 4'hB);
    check("post-reset data before debounce", bus.readdata, 32'h0);
    step(3'd0, 1'b0, 1'b1, 32'd0, 4'hB);
    check("post-reset data after debounce", bus.readdata, 32'hB);
    for (int a = 1; a <= 4; a++) begin
      step(3'(a), 1'b0, 1'b1, 32'd0, 4'hB);
      check($sformatf("post-reset reg%0d", a), bus.readdata, 32'h0);
    end
    step(3'd3, 1'b0, 1'b1, 32'd0, 4'hB);
    check("post-reset no capture", bus.readdata, 32'h0);
    check("post-reset irq", 32'(bus.irq), 32'h0);
    $display("reset-mid-debounce sequence done, data=%h", 4'hB);

    // Random traffic against the model.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
    rk = '0;
    for (int t = 0; t < 600; t++) begin
      logic [2:0]  ra;
      logic        rcs, rwn;
      logic [31:0] rwd;
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 7) == 0) rk[i] = ~rk[i];
      ra  = 3'($urandom_range(0, 7));
      rcs = 1'($urandom_range(0, 1));
      rwn = ($urandom_range(0, 3) != 0);
      rwd = $urandom;
      step(ra, rcs, rwn, rwd, rk);
      check($sformatf("rand%0d readdata", t), bus.readdata, m_rd);
      check($sformatf("rand%0d irq", t), 32'(bus.irq), 32'(|(m_cap & m_mask)));
    end
    $display("random phase done: 600 cycles");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
